imem_loader: RTL and testbench
==============================

# imem_loader

Program loader for the single-cycle RISC-V core. It accepts a little-endian byte stream over a valid/ready handshake and assembles each group of four bytes into a 32-bit instruction word. Each word is written into instruction memory at consecutive word addresses starting at 0. The core is held in reset (`core_rst`) until a load completes, so this block is the writer end of the instruction memory that the core's fetch stage reads.

## Interface
- `ADDR_W`, 6: instruction memory word-address width; depth = 2^ADDR_W words.
- `CLK`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load; sampled only in IDLE.
- `word_count`  in  ADDR_W+1  number of words to load; latched when `start` is accepted.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  stream byte; least significant byte of each word first.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction memory write enable.
- `imem_addr`  out  ADDR_W  word address for the write.
- `imem_wdata`  out  32  assembled instruction word.
- `core_rst`  out  1  active-high reset to the core.
- `busy`  out  1  a load is in progress.
- `done`  out  1  one-cycle pulse when a load completes.
- `err`  out  1  one-cycle pulse when a `start` is rejected.

## Operation
- States:
  - IDLE: waits for `start`.
  - RECV: accepts bytes.
  - WRITE: writes one word.
  - RELEASE: final cycle before handing the core back.
- IDLE:
  - `start`=1 with 1 ≤ `word_count` ≤ 2^ADDR_W: latch the count, clear the word index and byte index, assert `core_rst`, go to RECV.
  - `start`=1 with `word_count`=0 or > 2^ADDR_W: pulse `err`, stay in IDLE, leave `core_rst` unchanged.
- RECV:
  - `byte_ready`=1. A byte transfers on any cycle with `byte_valid`&&`byte_ready`.
  - The byte at byte index i goes into bits [8i+7:8i] of the word register; the byte index then increments.
  - On the transfer with byte index 3, go to WRITE.
  - With `byte_valid`=0 the word register and byte index hold.
- WRITE (one cycle):
  - `imem_we`=1, `imem_addr`=word index, `imem_wdata`=assembled word, `byte_ready`=0.
  - If word index = count−1, go to RELEASE. Otherwise increment the word index, clear the byte index and return to RECV.
- RELEASE (one cycle): `done`=1 and `core_rst`=1; the next state is IDLE, where `core_rst`=0.
- `busy`=1 in RECV, WRITE and RELEASE.
- `start` is ignored while `busy`=1.
- The word index does not wrap, because the count check at `start` bounds it.
- `imem_addr` and `imem_wdata` are don't-care while `imem_we`=0.

## Timing
- Reset values (rst_n=0):
  - state IDLE, and word index, byte index and word register cleared.
  - `byte_ready`, `imem_we`, `busy`, `done` and `err` = 0.
  - `imem_addr`=0, `imem_wdata`=0.
  - `core_rst`=1, so the core stays held after power-up until the first completed load.
- Reset is asynchronous: asserting `rst_n` mid-load aborts immediately to the reset values. Words already written remain in memory, and the next load restarts at address 0.
- `start` accepted at edge t: `byte_ready`=1 from t.
- With `byte_valid` held high, the 4th byte transfers at edge t+4, `imem_we`=1 during cycle t+4..t+5, and memory samples the word at edge t+5.
- Throughput: at best 5 cycles per word (4 accept cycles + 1 write cycle).
- Last WRITE ends at edge e: `done`=1 during e..e+1, and `core_rst` falls at edge e+1.
- `err` is high for exactly one cycle, the cycle after the rejected `start` edge.
- All outputs are registered or decoded from state only. No combinational path runs from `byte_valid` to `byte_ready`.

## Test plan
- Reset: hold `rst_n`=0 → `core_rst`=1, `busy`=0, `imem_we`=0, `byte_ready`=0; release and idle 3 cycles → nothing changes.
- Four-word load, `word_count`=4, bytes B3 81 11 40 33 22 31 00 63 04 02 00 B3 02 11 00 sent back-to-back → exactly 4 writes:
  - addr0=0x401181B3 (sub x3,x3,x1)
  - addr1=0x00312233 (slt x4,x2,x3)
  - addr2=0x00020463 (beq x4,x0,+8)
  - addr3=0x001102B3 (add x5,x2,x1)
  - then one `done` pulse, followed by `core_rst` low.
- Gapped stream: random `byte_valid` gaps of 0–3 cycles with `word_count`=2 → same words as the gap-free case; `byte_ready`=0 on every WRITE cycle; no byte lost or duplicated.
- Bad count: `start` with `word_count`=0, then with `word_count`=65 (ADDR_W=6) → one `err` pulse each; no `imem_we`; `busy` stays 0.
- Reset mid-load: assert `rst_n`=0 after 6 bytes of a 4-word load → outputs return to reset values immediately; a fresh load then writes its first word to addr 0.
- `start` pulsed while `busy`=1 → ignored; the count and addresses of the current load are unaffected.

Source files
------------

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Byte stream, control and instruction-memory write signals
//               of the program loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
  parameter int ADDR_W = 6
) ();
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic              err;

  // Loader side
  modport slave (
    input  start, word_count, byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata,
           core_rst, busy, done, err
  );

  // Host / byte source side
  modport master (
    output start, word_count, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata,
           core_rst, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Assembles a little-endian byte stream into 32-bit words and
//               writes them to instruction memory from address 0, holding the
//               core in reset until the load completes.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  wire          CLK,
  input  wire          rst_n,
  imem_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RECV    = 2'd1,
    S_WRITE   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  // Largest legal count: the full memory depth.
  localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] widx_q;
  logic [1:0]        bidx_q;
  logic [31:0]       word_q;
  logic              byte_ready_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic              core_rst_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              count_ok;
  logic              last_word;

  assign count_ok  = (bus.word_count != '0) && (bus.word_count <= WORDS_MAX);
  assign last_word = ({1'b0, widx_q} == (count_q - 1'b1));

  // Loader FSM; every output is a register so byte_ready never depends
  // combinationally on byte_valid.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      widx_q       <= '0;
      bidx_q       <= '0;
      word_q       <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          err_q  <= 1'b0;
          done_q <= 1'b0;
          if (bus.start) begin
            if (count_ok) begin
              count_q      <= bus.word_count;
              widx_q       <= '0;
              bidx_q       <= '0;
              core_rst_q   <= 1'b1;
              byte_ready_q <= 1'b1;
              busy_q       <= 1'b1;
              state_q      <= S_RECV;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        S_RECV: begin
          // byte_ready is always high here, so byte_valid alone means a transfer.
          if (bus.byte_valid) begin
            case (bidx_q)
              2'd0:    word_q[7:0]   <= bus.byte_data;
              2'd1:    word_q[15:8]  <= bus.byte_data;
              2'd2:    word_q[23:16] <= bus.byte_data;
              default: word_q[31:24] <= bus.byte_data;
            endcase
            bidx_q <= bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= widx_q;
              imem_wdata_q <= {bus.byte_data, word_q[23:0]};
              byte_ready_q <= 1'b0;
              state_q      <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          imem_we_q <= 1'b0;
          if (last_word) begin
            done_q  <= 1'b1;
            state_q <= S_RELEASE;
          end else begin
            widx_q       <= widx_q + 1'b1;
            bidx_q       <= '0;
            byte_ready_q <= 1'b1;
            state_q      <= S_RECV;
          end
        end

        default: begin
          done_q     <= 1'b0;
          core_rst_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.core_rst   = core_rst_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Scoreboard bench for imem_loader: stimulus pushes expected
//               memory writes, a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;
  localparam int ADDR_W = 6;

  logic CLK = 1'b0;
  logic rst_n;

  always #5 CLK = ~CLK;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp    = 0;
  int n_bad    = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [31:0]       exp_data_q[$];
  logic [ADDR_W-1:0] mon_addr;
  logic [31:0]       mon_data;

  logic [7:0] stream [16] = '{8'hB3, 8'h81, 8'h11, 8'h40,
                              8'h33, 8'h22, 8'h31, 8'h00,
                              8'h63, 8'h04, 8'h02, 8'h00,
                              8'hB3, 8'h02, 8'h11, 8'h00};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  // Monitor: counts pulses and checks every memory write against the scoreboard.
  always @(negedge CLK) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.err === 1'b1) err_cnt++;
    if (bus.imem_we === 1'b1) begin
      chk("ready_low_on_write", {31'd0, bus.byte_ready}, 32'd0);
      if (exp_addr_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data 0x%08h expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        mon_addr = exp_addr_q.pop_front();
        mon_data = exp_data_q.pop_front();
        chk("write_addr", {26'd0, bus.imem_addr}, {26'd0, mon_addr});
        chk("write_data", bus.imem_wdata, mon_data);
      end
    end
  end

  // Called at #1 after a rising edge; start is seen at the following edge.
  task automatic do_start(input logic [ADDR_W:0] cnt);
    bus.start      = 1'b1;
    bus.word_count = cnt;
    @(posedge CLK); #1;
    bus.start = 1'b0;
  endtask

  // Presents one byte after 'gap' idle cycles and returns #1 after it transfers.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    bit   ok;
    bus.byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge CLK); #1;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      rdy = bus.byte_ready;
      @(posedge CLK); #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL byte_accept_timeout: got byte_ready 0 expected 1 within 50 cycles");
    end
  endtask

  // Waits for the done pulse count to reach 'target', then checks the hand-back.
  task automatic wait_done(input int target);
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK); #1;
      if (done_cnt >= target) break;
    end
    chk("done_count", done_cnt, target);
    @(negedge CLK); #1;
    chk("core_rst_after_done", {31'd0, bus.core_rst}, 32'd0);
    chk("done_single_cycle", {31'd0, bus.done}, 32'd0);
    chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
    @(posedge CLK); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.word_count = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Reset values, then three idle cycles with nothing changing.
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_core_rst", {31'd0, bus.core_rst}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_imem_we", {31'd0, bus.imem_we}, 32'd0);
    chk("rst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("rst_done_err", {30'd0, bus.done, bus.err}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("idle_core_rst", {31'd0, bus.core_rst}, 32'd1);
      chk("idle_busy_ready", {30'd0, bus.busy, bus.byte_ready}, 32'd0);
    end
    @(posedge CLK); #1;

    // Four-word load, back-to-back bytes.
    expect_write(6'd0, 32'h401181B3);
    expect_write(6'd1, 32'h00312233);
    expect_write(6'd2, 32'h00020463);
    expect_write(6'd3, 32'h001102B3);
    do_start(7'd4);
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    chk("ready_after_start", {31'd0, bus.byte_ready}, 32'd1);
    for (int i = 0; i < 16; i++) send_byte(stream[i], 0);
    bus.byte_valid = 1'b0;
    wait_done(1);

    // Two-word load with random gaps of 0..3 cycles between bytes.
    expect_write(6'd0, 32'h401181B3);
    expect_write(6'd1, 32'h00312233);
    do_start(7'd2);
    for (int i = 0; i < 8; i++) send_byte(stream[i], int'($urandom_range(0, 3)));
    bus.byte_valid = 1'b0;
    wait_done(2);

    // Rejected counts: zero and one beyond the memory depth.
    do_start(7'd0);
    chk("err_cnt0", {31'd0, bus.err}, 32'd1);
    chk("busy_cnt0", {31'd0, bus.busy}, 32'd0);
    @(posedge CLK); #1;
    chk("err_pulse_end0", {31'd0, bus.err}, 32'd0);
    do_start(7'd65);
    chk("err_cnt65", {31'd0, bus.err}, 32'd1);
    chk("busy_cnt65", {31'd0, bus.busy}, 32'd0);
    chk("core_rst_kept", {31'd0, bus.core_rst}, 32'd0);
    @(posedge CLK); #1;
    chk("err_pulse_end65", {31'd0, bus.err}, 32'd0);

    // start while busy must not disturb the running load.
    expect_write(6'd0, 32'h00020463);
    expect_write(6'd1, 32'h001102B3);
    do_start(7'd2);
    for (int i = 8; i < 11; i++) send_byte(stream[i], 0);
    bus.byte_valid = 1'b0;
    do_start(7'd1);
    chk("busy_start_ignored", {30'd0, bus.busy, bus.err}, 32'd2);
    for (int i = 11; i < 16; i++) send_byte(stream[i], 0);
    bus.byte_valid = 1'b0;
    wait_done(3);

    // Reset after six bytes of a four-word load, then a fresh one-word load.
    expect_write(6'd0, 32'h401181B3);
    do_start(7'd4);
    for (int i = 0; i < 6; i++) send_byte(stream[i], 0);
    rst_n          = 1'b0;
    bus.byte_valid = 1'b0;
    #1;
    chk("midrst_core_rst", {31'd0, bus.core_rst}, 32'd1);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("midrst_we_done", {30'd0, bus.imem_we, bus.done}, 32'd0);
    @(posedge CLK); #1;
    rst_n = 1'b1;
    @(posedge CLK); #1;
    expect_write(6'd0, 32'h00312233);
    do_start(7'd1);
    for (int i = 4; i < 8; i++) send_byte(stream[i], 0);
    bus.byte_valid = 1'b0;
    wait_done(4);

    repeat (3) @(posedge CLK);
    #1;
    chk("scoreboard_empty", exp_addr_q.size(), 32'd0);
    chk("err_total", err_cnt, 32'd2);
    chk("done_total", done_cnt, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
